// File: rtl/wb_req_arbiter.sv
// -----------------------------------------------------------------------------
// wb_req_arbiter
//
// Shares one wb_master between two CPU-side requesters (port 0: instruction
// fetch, port 1: load/store) with round-robin arbitration. One request is
// latched at a time and launched to the master as a one-cycle start pulse.
// The master's done (plus read data) is returned to the granted requester as a
// one-cycle done pulse.
//
// Ports
//   clk_i, rst_ni            clock (rising edge), synchronous active-low reset
//   pN_req_i                 request, held with stable fields until pN_done_o
//   pN_we_i                  1 = write, 0 = read
//   pN_sel_i / addr / data   byte select, address, write data
//   pN_done_o                one-cycle completion pulse
//   pN_data_o                read data (0 for writes), valid with pN_done_o
//   m_start_rd_o/_wr_o       one-cycle start pulses to the wb_master
//   m_sel_o/addr_o/data_o    request fields to the master (0 when idle)
//   m_done_i, m_data_i       master completion pulse and read data
//   busy_o                   a transaction is in flight
//   grant_o                  port being served, meaningful while busy_o = 1
//
// Handshake: a requester raises pN_req_i with stable fields and keeps them
// until it sees pN_done_o for one cycle. The arbiter samples req only in IDLE,
// so a req still high in the done cycle is not seen; a req high in the IDLE
// cycle that follows is a new request. Toward the master, exactly one start
// pulse is issued per transaction and exactly one m_done_i pulse (taken in
// WAIT only) ends it.
//
// Every output is a flop. The output logic computes each output's value for
// the coming cycle from the next state, so a request sampled in IDLE in cycle
// N shows its start pulse in cycle N+1, and m_done_i in cycle D gives done_o
// in cycle D+1.
// -----------------------------------------------------------------------------
module wb_req_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    // port 0: instruction fetch
    input  logic                    p0_req_i,
    input  logic                    p0_we_i,
    input  logic [DATA_WIDTH/8-1:0] p0_sel_i,
    input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
    input  logic [DATA_WIDTH-1:0]   p0_data_i,
    output logic                    p0_done_o,
    output logic [DATA_WIDTH-1:0]   p0_data_o,

    // port 1: load/store
    input  logic                    p1_req_i,
    input  logic                    p1_we_i,
    input  logic [DATA_WIDTH/8-1:0] p1_sel_i,
    input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
    input  logic [DATA_WIDTH-1:0]   p1_data_i,
    output logic                    p1_done_o,
    output logic [DATA_WIDTH-1:0]   p1_data_o,

    // wb_master command side
    output logic                    m_start_rd_o,
    output logic                    m_start_wr_o,
    output logic [DATA_WIDTH/8-1:0] m_sel_o,
    output logic [ADDR_WIDTH-1:0]   m_addr_o,
    output logic [DATA_WIDTH-1:0]   m_data_o,
    input  logic                    m_done_i,
    input  logic [DATA_WIDTH-1:0]   m_data_i,

    // status
    output logic                    busy_o,
    output logic                    grant_o
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    state_e state_q, state_d;

    // last_grant doubles as "port currently served" once a grant is made.
    logic                  last_grant_q, last_grant_d;
    logic                  req_we_q,     req_we_d;
    logic [SEL_WIDTH-1:0]  req_sel_q,    req_sel_d;
    logic [ADDR_WIDTH-1:0] req_addr_q,   req_addr_d;
    logic [DATA_WIDTH-1:0] req_data_q,   req_data_d;

    // Next values of the registered outputs.
    logic                  busy_d;
    logic                  grant_d;
    logic                  m_start_rd_d;
    logic                  m_start_wr_d;
    logic [SEL_WIDTH-1:0]  m_sel_d;
    logic [ADDR_WIDTH-1:0] m_addr_d;
    logic [DATA_WIDTH-1:0] m_data_d;
    logic                  p0_done_d;
    logic [DATA_WIDTH-1:0] p0_data_d;
    logic                  p1_done_d;
    logic [DATA_WIDTH-1:0] p1_data_d;

    logic                  any_req;
    logic                  win_port;
    logic                  bus_active;
    logic [DATA_WIDTH-1:0] resp_data;

    // -------------------------------------------------------------------------
    // Arbitration: a lone requester wins; on contention the port that was not
    // served last wins.
    // -------------------------------------------------------------------------
    assign any_req = p0_req_i | p1_req_i;

    always_comb begin
        win_port = p1_req_i;
        if (p0_req_i && p1_req_i) begin
            win_port = ~last_grant_q;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // m_done_i is only meaningful here; elsewhere it is ignored.
                if (m_done_i) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                // One cooldown cycle so a req still held during done is not
                // re-served.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Request latch: fields of the winner are captured at grant and held for
    // the whole transaction, so later changes on the requester side are
    // ignored.
    // -------------------------------------------------------------------------
    always_comb begin
        last_grant_d = last_grant_q;
        req_we_d     = req_we_q;
        req_sel_d    = req_sel_q;
        req_addr_d   = req_addr_q;
        req_data_d   = req_data_q;
        if (state_q == ST_IDLE && any_req) begin
            last_grant_d = win_port;
            if (win_port) begin
                req_we_d   = p1_we_i;
                req_sel_d  = p1_sel_i;
                req_addr_d = p1_addr_i;
                req_data_d = p1_data_i;
            end else begin
                req_we_d   = p0_we_i;
                req_sel_d  = p0_sel_i;
                req_addr_d = p0_addr_i;
                req_data_d = p0_data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_grant_q <= 1'b1;  // port 0 wins the first contention
            req_we_q     <= 1'b0;
            req_sel_q    <= '0;
            req_addr_q   <= '0;
            req_data_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            req_we_q     <= req_we_d;
            req_sel_q    <= req_sel_d;
            req_addr_q   <= req_addr_d;
            req_data_q   <= req_data_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: output logic (values for the next cycle, registered below)
    // -------------------------------------------------------------------------
    assign bus_active = (state_d == ST_ISSUE) || (state_d == ST_WAIT);

    // Entering RESP only happens from WAIT with m_done_i high, so m_data_i is
    // valid whenever this is used. Writes return zero.
    assign resp_data = req_we_q ? '0 : m_data_i;

    always_comb begin
        busy_d       = (state_d != ST_IDLE);
        grant_d      = busy_d ? last_grant_d : 1'b0;

        m_start_rd_d = (state_d == ST_ISSUE) && !req_we_d;
        m_start_wr_d = (state_d == ST_ISSUE) &&  req_we_d;
        m_sel_d      = bus_active ? req_sel_d  : '0;
        m_addr_d     = bus_active ? req_addr_d : '0;
        m_data_d     = bus_active ? req_data_d : '0;

        p0_done_d    = 1'b0;
        p0_data_d    = '0;
        p1_done_d    = 1'b0;
        p1_data_d    = '0;
        if (state_d == ST_RESP) begin
            if (last_grant_q) begin
                p1_done_d = 1'b1;
                p1_data_d = resp_data;
            end else begin
                p0_done_d = 1'b1;
                p0_data_d = resp_data;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            busy_o       <= 1'b0;
            grant_o      <= 1'b0;
            m_start_rd_o <= 1'b0;
            m_start_wr_o <= 1'b0;
            m_sel_o      <= '0;
            m_addr_o     <= '0;
            m_data_o     <= '0;
            p0_done_o    <= 1'b0;
            p0_data_o    <= '0;
            p1_done_o    <= 1'b0;
            p1_data_o    <= '0;
        end else begin
            busy_o       <= busy_d;
            grant_o      <= grant_d;
            m_start_rd_o <= m_start_rd_d;
            m_start_wr_o <= m_start_wr_d;
            m_sel_o      <= m_sel_d;
            m_addr_o     <= m_addr_d;
            m_data_o     <= m_data_d;
            p0_done_o    <= p0_done_d;
            p0_data_o    <= p0_data_d;
            p1_done_o    <= p1_done_d;
            p1_data_o    <= p1_data_d;
        end
    end

endmodule

// File: tb/tb_wb_req_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for wb_req_arbiter. Requester drivers and a wb_master responder drive
// the DUT; a transaction-level reference model (runs at posedge) pushes the
// expected start and response of each transaction into queues; a monitor at
// negedge pops and compares against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_wb_req_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    logic rst_ni;
    initial forever #5 clk_i = ~clk_i;

    // ---------------- DUT connections ----------------
    logic          req   [2];
    logic          we    [2];
    logic [SW-1:0] sel   [2];
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wdata [2];

    logic          p0_done_o, p1_done_o;
    logic [DW-1:0] p0_data_o, p1_data_o;
    logic          m_start_rd_o, m_start_wr_o;
    logic [SW-1:0] m_sel_o;
    logic [AW-1:0] m_addr_o;
    logic [DW-1:0] m_data_o;
    logic          m_done;
    logic [DW-1:0] m_data;
    logic          busy_o, grant_o;

    wb_req_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .p0_req_i     (req[0]),
        .p0_we_i      (we[0]),
        .p0_sel_i     (sel[0]),
        .p0_addr_i    (addr[0]),
        .p0_data_i    (wdata[0]),
        .p0_done_o    (p0_done_o),
        .p0_data_o    (p0_data_o),
        .p1_req_i     (req[1]),
        .p1_we_i      (we[1]),
        .p1_sel_i     (sel[1]),
        .p1_addr_i    (addr[1]),
        .p1_data_i    (wdata[1]),
        .p1_done_o    (p1_done_o),
        .p1_data_o    (p1_data_o),
        .m_start_rd_o (m_start_rd_o),
        .m_start_wr_o (m_start_wr_o),
        .m_sel_o      (m_sel_o),
        .m_addr_o     (m_addr_o),
        .m_data_o     (m_data_o),
        .m_done_i     (m_done),
        .m_data_i     (m_data),
        .busy_o       (busy_o),
        .grant_o      (grant_o)
    );

    // ---------------- scoreboard state ----------------
    // start entry: {port, we, sel, addr, wdata}; response entry: {port, rdata}
    logic [69:0] exp_start_q[$];
    logic [32:0] exp_resp_q[$];
    logic        start_ports[$];

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 0;

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Transaction view: one open transaction at a time; a grant opens it, an
    // m_done no earlier than two cycles after the grant closes it, and the next
    // grant may come no earlier than two cycles after that done.
    int            cyc       = 0;
    bit            open      = 0;
    int            grant_cyc = 0;
    int            next_arb  = 0;
    logic          last      = 1'b1;
    logic          cur_port  = 1'b0;
    logic          cur_we    = 1'b0;
    logic [SW-1:0] cur_sel   = '0;
    logic [AW-1:0] cur_addr  = '0;
    logic [DW-1:0] cur_data  = '0;

    always @(posedge clk_i) begin
        logic w;
        cyc++;
        if (!rst_ni) begin
            open = 0;
            last = 1'b1;
            next_arb = 0;
            exp_start_q.delete();
            exp_resp_q.delete();
        end else if (open) begin
            if (m_done && cyc >= grant_cyc + 2) begin
                exp_resp_q.push_back({cur_port, cur_we ? {DW{1'b0}} : m_data});
                open = 0;
                next_arb = cyc + 2;
            end
        end else if (cyc >= next_arb && (req[0] || req[1])) begin
            if (req[0] && req[1]) w = ~last;
            else                  w = req[1];
            last      = w;
            cur_port  = w;
            cur_we    = we[w];
            cur_sel   = sel[w];
            cur_addr  = addr[w];
            cur_data  = wdata[w];
            open      = 1;
            grant_cyc = cyc;
            exp_start_q.push_back({w, we[w], sel[w], addr[w], wdata[w]});
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk_i) begin
        logic [69:0] es;
        logic [32:0] rf;
        bit          have_resp;
        if (mon_en) begin
            have_resp = (exp_resp_q.size() != 0);
            rf = have_resp ? exp_resp_q[0] : '0;

            chk("busy", busy_o, open || have_resp);
            if (open || have_resp) chk("grant", grant_o, open ? cur_port : rf[32]);

            if (m_start_rd_o || m_start_wr_o) start_ports.push_back(grant_o);
            if (exp_start_q.size() != 0) begin
                es = exp_start_q.pop_front();
                chk("start_kind", {m_start_rd_o, m_start_wr_o}, es[68] ? 2'b01 : 2'b10);
                chk("start_port", grant_o, es[69]);
                chk("start_fields", {m_sel_o, m_addr_o, m_data_o}, es[67:0]);
            end else begin
                chk("no_start", {m_start_rd_o, m_start_wr_o}, 2'b00);
            end

            if (open) chk("bus_hold", {m_sel_o, m_addr_o, m_data_o}, {cur_sel, cur_addr, cur_data});
            else      chk("bus_idle", {m_sel_o, m_addr_o, m_data_o}, '0);

            chk("p0_resp", {p0_done_o, p0_data_o},
                (have_resp && rf[32] == 1'b0) ? {1'b1, rf[31:0]} : 33'd0);
            chk("p1_resp", {p1_done_o, p1_data_o},
                (have_resp && rf[32] == 1'b1) ? {1'b1, rf[31:0]} : 33'd0);
            if (have_resp) void'(exp_resp_q.pop_front());
        end
    end

    // ---------------- wb_master responder ----------------
    bit            use_fix      = 0;
    int            fix_delay    = 1;
    logic [DW-1:0] fix_data     = '0;
    bit            spurious_req = 0;

    initial begin
        int d;
        m_done = 1'b0;
        m_data = '0;
        forever begin
            @(negedge clk_i);
            if (rst_ni && (m_start_rd_o || m_start_wr_o)) begin
                d = use_fix ? fix_delay : int'($urandom_range(1, 5));
                repeat (d) @(negedge clk_i);
                m_done = 1'b1;
                m_data = use_fix ? fix_data : DW'($urandom);
                @(negedge clk_i);
                m_done = 1'b0;
            end else if (spurious_req) begin
                m_done = 1'b1;
                m_data = DW'($urandom);
                @(negedge clk_i);
                m_done = 1'b0;
                spurious_req = 0;
            end
        end
    end

    // ---------------- requester driver tasks ----------------
    function automatic logic port_done(input int p);
        return (p == 0) ? p0_done_o : p1_done_o;
    endfunction

    task automatic wait_done(input int p, input int mut_after);
        bit got = 0;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk_i);
            if (mut_after != 0 && n == mut_after) addr[p] = addr[p] ^ 32'h30;
            if (port_done(p)) begin
                got = 1;
                break;
            end
        end
        chk("done_seen", got, 1'b1);
    endtask

    task automatic do_txn(input int p, input logic w, input logic [SW-1:0] s,
                          input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int mut_after, input bit hold);
        @(negedge clk_i);
        req[p] = 1'b1; we[p] = w; sel[p] = s; addr[p] = a; wdata[p] = d;
        wait_done(p, mut_after);
        if (hold) begin
            // Keep req through the IDLE cycle after done: that is a new request.
            repeat (2) @(negedge clk_i);
            req[p] = 1'b0;
            wait_done(p, 0);
        end else begin
            req[p] = 1'b0;
        end
    endtask

    task automatic rand_fields(input int p);
        we[p]    = 1'($urandom_range(0, 1));
        sel[p]   = SW'($urandom);
        addr[p]  = AW'($urandom);
        wdata[p] = DW'($urandom);
    endtask

    // Back-to-back transactions with req held high throughout.
    task automatic port_burst(input int p, input int n);
        @(negedge clk_i);
        req[p] = 1'b1;
        rand_fields(p);
        for (int k = 0; k < n; k++) begin
            wait_done(p, 0);
            if (k < n - 1) rand_fields(p);
        end
        req[p] = 1'b0;
    endtask

    task automatic port_rand(input int p, input int n);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk_i);
            do_txn(p, 1'($urandom_range(0, 1)), SW'($urandom), AW'($urandom), DW'($urandom),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, 1'b0);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        repeat (50000) @(posedge clk_i);
        n_checks++;
        $display("FAIL watchdog: simulation did not finish within cycle budget");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [3:0] order;
        bit         got;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; sel[i] = '0; addr[i] = '0; wdata[i] = '0;
        end
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        mon_en = 1;
        chk("reset_ctrl", {busy_o, grant_o, m_start_rd_o, m_start_wr_o, p0_done_o, p1_done_o}, '0);
        rst_ni = 1'b1;

        // single read on port 0
        use_fix = 1; fix_delay = 3; fix_data = 32'hDEAD_BEEF;
        do_txn(0, 1'b0, 4'hF, 32'h0000_0100, 32'h0, 0, 1'b0);

        // single write on port 1
        fix_data = 32'hCAFE_F00D;
        do_txn(1, 1'b1, 4'h3, 32'h2000_0004, 32'h1234_5678, 0, 1'b0);

        // contention fairness
        use_fix = 0;
        start_ports.delete();
        fork
            port_burst(0, 2);
            port_burst(1, 2);
        join
        order = '1;
        for (int i = 0; i < 4 && i < start_ports.size(); i++) order[i] = start_ports[i];
        chk("rr_order", order, 4'b1010);

        // req held one cycle after done: exactly one more transaction
        start_ports.delete();
        do_txn(0, 1'b0, 4'hF, 32'h0000_0300, 32'h0, 0, 1'b1);
        chk("held_req_txns", start_ports.size(), 2);

        // spurious done in IDLE, then field change during WAIT
        spurious_req = 1;
        repeat (5) @(negedge clk_i);
        use_fix = 1; fix_delay = 5; fix_data = 32'h0BAD_F00D;
        do_txn(0, 1'b0, 4'hF, 32'h0000_0010, 32'h0, 3, 1'b0);

        // reset during WAIT; the master's late done must be ignored
        fix_delay = 8;
        @(negedge clk_i);
        req[0] = 1'b1; we[0] = 1'b0; sel[0] = 4'hF; addr[0] = 32'h400;
        got = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk_i);
            if (m_start_rd_o) begin
                got = 1;
                break;
            end
        end
        chk("rst_test_start", got, 1'b1);
        @(negedge clk_i);
        rst_ni = 1'b0;
        req[0] = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        chk("rst_ctrl", {busy_o, grant_o, m_start_rd_o, m_start_wr_o, p0_done_o, p1_done_o, m_sel_o, m_addr_o}, '0);
        chk("rst_data", {m_data_o, p0_data_o}, '0);
        repeat (12) @(negedge clk_i);

        // both request after reset: port 0 goes first
        use_fix = 0;
        start_ports.delete();
        fork
            do_txn(0, 1'b1, 4'h1, 32'h0000_0500, 32'h5555_0000, 0, 1'b0);
            do_txn(1, 1'b0, 4'h8, 32'h0000_0600, 32'h0, 0, 1'b0);
        join
        order = '1;
        for (int i = 0; i < 2 && i < start_ports.size(); i++) order[i] = start_ports[i];
        chk("order_after_reset", order[1:0], 2'b10);

        // randomized traffic on both ports
        fork
            port_rand(0, 25);
            port_rand(1, 25);
        join

        repeat (6) @(negedge clk_i);
        chk("drain", exp_start_q.size() + exp_resp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
